pic_ack_eoi_controller: RTL and testbench

- Interrupt-acknowledge and end-of-interrupt sequencer for the 8259A-compatible PIC, 8086 mode only.
- Initiator side of the in-service register interface: drives `latch_in_service`, `end_of_interrupt` and `priority_rotate` into the in-service block.
- Tracks the CPU two-pulse INTA sequence and returns the interrupt vector on the second pulse.
- Decodes OCW2 writes into EOI and rotation commands.

---
 rtl/pic_ack_eoi_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_pic_ack_eoi_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_eoi_controller.sv
// rtl/pic_ack_eoi_controller.sv - 8259A (8086 mode) INTA sequencer and OCW2 EOI/rotate decoder
// Optional automatic EOI on the second INTA rise is built when PIC_AUTO_EOI_EN is defined.
module pic_ack_eoi_controller #(
    parameter int INTA_SYNC_STAGES   = 2,
    parameter int ACK_TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_acknowledge_n,
    input  logic [7:0] interrupt,
    input  logic [7:0] highest_level_in_service,
    input  logic [4:0] interrupt_vector_base,
    input  logic       auto_eoi_config,
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    output logic       latch_in_service,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_enable,
    output logic       ack_in_progress
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK1      = 2'd1,
        ACK1_WAIT = 2'd2,
        ACK2      = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(ACK_TIMEOUT_CYCLES);

    function automatic logic [2:0] encode8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // INTA synchronizer; idle-high so reset never fabricates a falling edge
    logic [INTA_SYNC_STAGES-1:0] inta_sync;
    logic                        inta_sync_d;
    logic                        inta_fall;
    logic                        inta_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            inta_sync   <= '1;
            inta_sync_d <= 1'b1;
        end else begin
            inta_sync   <= {inta_sync[INTA_SYNC_STAGES-2:0], interrupt_acknowledge_n};
            inta_sync_d <= inta_sync[INTA_SYNC_STAGES-1];
        end
    end

    assign inta_fall = inta_sync_d & ~inta_sync[INTA_SYNC_STAGES-1];
    assign inta_rise = ~inta_sync_d & inta_sync[INTA_SYNC_STAGES-1];

    state_t     state;
    state_t     state_next;
    logic [7:0] timeout_count;
    logic [7:0] count_next;
    logic [2:0] level;
    logic [2:0] level_next;
    logic       spurious;
    logic       spurious_next;
    logic       latch_next;
    logic       auto_eoi_fire;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            timeout_count <= 8'd0;
            level         <= 3'd0;
            spurious      <= 1'b0;
        end else begin
            state         <= state_next;
            timeout_count <= count_next;
            level         <= level_next;
            spurious      <= spurious_next;
        end
    end

    always_comb begin
        state_next    = state;
        count_next    = timeout_count;
        level_next    = level;
        spurious_next = spurious;
        latch_next    = 1'b0;
        auto_eoi_fire = 1'b0;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    state_next = ACK1;
                    if (interrupt == 8'd0) begin
                        level_next    = 3'd7;
                        spurious_next = 1'b1;
                    end else begin
                        level_next    = encode8(interrupt);
                        spurious_next = 1'b0;
                        latch_next    = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    state_next = ACK1_WAIT;
                    count_next = 8'd0;
                end
            end
            ACK1_WAIT: begin
                if (inta_fall) begin
                    state_next = ACK2;
                end else if (timeout_count == TIMEOUT_LIMIT) begin
                    state_next = IDLE;
                end else begin
                    count_next = timeout_count + 8'd1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_next    = IDLE;
                    auto_eoi_fire = ~spurious;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // OCW2 decode; results land in the output registers on the write edge
    logic [7:0] ocw_eoi;
    logic       ocw_rot_valid;
    logic [2:0] ocw_rot;
    logic       ocw_aeoi_set;
    logic       ocw_aeoi_clr;
    logic [7:0] specific_mask;

    assign specific_mask = 8'd1 << ocw2_data[2:0];

    always_comb begin
        ocw_eoi       = 8'd0;
        ocw_rot_valid = 1'b0;
        ocw_rot       = 3'd0;
        ocw_aeoi_set  = 1'b0;
        ocw_aeoi_clr  = 1'b0;
        if (ocw2_write) begin
            case (ocw2_data[7:5])
                3'b001: ocw_eoi = highest_level_in_service;
                3'b011: ocw_eoi = specific_mask;
                3'b101: begin
                    if (highest_level_in_service != 8'd0) begin
                        ocw_eoi       = highest_level_in_service;
                        ocw_rot_valid = 1'b1;
                        ocw_rot       = encode8(highest_level_in_service);
                    end
                end
                3'b111: begin
                    ocw_eoi       = specific_mask;
                    ocw_rot_valid = 1'b1;
                    ocw_rot       = ocw2_data[2:0];
                end
                3'b110: begin
                    ocw_rot_valid = 1'b1;
                    ocw_rot       = ocw2_data[2:0];
                end
                3'b100:  ocw_aeoi_set = 1'b1;
                3'b000:  ocw_aeoi_clr = 1'b1;
                default: ;
            endcase
        end
    end

    logic       rotate_in_aeoi;
    logic [7:0] aeoi_eoi;
    logic       aeoi_rot_valid;

`ifdef PIC_AUTO_EOI_EN
    logic aeoi_active;
    assign aeoi_active    = auto_eoi_fire & auto_eoi_config;
    assign aeoi_eoi       = aeoi_active ? (8'd1 << level) : 8'd0;
    assign aeoi_rot_valid = aeoi_active & rotate_in_aeoi;

    always_ff @(posedge clock) begin
        if (reset) begin
            rotate_in_aeoi <= 1'b0;
        end else if (ocw_aeoi_set) begin
            rotate_in_aeoi <= 1'b1;
        end else if (ocw_aeoi_clr) begin
            rotate_in_aeoi <= 1'b0;
        end
    end
`else
    logic unused_aeoi;
    assign rotate_in_aeoi = 1'b0;
    assign aeoi_eoi       = 8'd0;
    assign aeoi_rot_valid = 1'b0;
    assign unused_aeoi    = auto_eoi_config ^ auto_eoi_fire ^ ocw_aeoi_set ^ ocw_aeoi_clr
                            ^ rotate_in_aeoi;
`endif

    logic [1:0] unused_ocw2_bits;
    assign unused_ocw2_bits = ocw2_data[4:3];

    always_ff @(posedge clock) begin
        if (reset) begin
            latch_in_service <= 1'b0;
            end_of_interrupt <= 8'd0;
            priority_rotate  <= 3'd7;
            data_out         <= 8'd0;
            data_out_enable  <= 1'b0;
            ack_in_progress  <= 1'b0;
        end else begin
            latch_in_service <= latch_next;
            end_of_interrupt <= ocw_eoi | aeoi_eoi;
            data_out_enable  <= (state_next == ACK2);
            ack_in_progress  <= (state_next != IDLE);
            if (state_next == ACK2) begin
                data_out <= {interrupt_vector_base, level_next};
            end
            // OCW2 rotation overrides the automatic one when both land together
            if (ocw_rot_valid) begin
                priority_rotate <= ocw_rot;
            end else if (aeoi_rot_valid) begin
                priority_rotate <= level;
            end
        end
    end

endmodule

// File: tb/tb_pic_ack_eoi_controller.sv
// tb/tb_pic_ack_eoi_controller.sv - directed self-checking bench for pic_ack_eoi_controller
module tb_pic_ack_eoi_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       interrupt_acknowledge_n = 1'b1;
    logic [7:0] interrupt = 8'd0;
    logic [7:0] highest_level_in_service = 8'd0;
    logic [4:0] interrupt_vector_base = 5'd0;
    logic       auto_eoi_config = 1'b0;
    logic       ocw2_write = 1'b0;
    logic [7:0] ocw2_data = 8'd0;
    logic       latch_in_service;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [7:0] data_out;
    logic       data_out_enable;
    logic       ack_in_progress;

    int passed = 0;
    int total  = 0;
    int latch_count = 0;
    int doe_count = 0;
    logic [7:0] eoi_or = 8'd0;

    pic_ack_eoi_controller dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt_acknowledge_n  (interrupt_acknowledge_n),
        .interrupt                (interrupt),
        .highest_level_in_service (highest_level_in_service),
        .interrupt_vector_base    (interrupt_vector_base),
        .auto_eoi_config          (auto_eoi_config),
        .ocw2_write               (ocw2_write),
        .ocw2_data                (ocw2_data),
        .latch_in_service         (latch_in_service),
        .end_of_interrupt         (end_of_interrupt),
        .priority_rotate          (priority_rotate),
        .data_out                 (data_out),
        .data_out_enable          (data_out_enable),
        .ack_in_progress          (ack_in_progress)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (latch_in_service) latch_count++;
        if (data_out_enable) doe_count++;
        eoi_or |= end_of_interrupt;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic clear_monitors();
        latch_count = 0;
        doe_count   = 0;
        eoi_or      = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic write_ocw2(input logic [7:0] d);
        ocw2_data  = d;
        ocw2_write = 1'b1;
        tick(1);
        ocw2_write = 1'b0;
    endtask

    task automatic inta_pulse_low(input int n);
        interrupt_acknowledge_n = 1'b0;
        tick(n);
        interrupt_acknowledge_n = 1'b1;
        tick(n);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_latch", {7'd0, latch_in_service}, 8'd0);
        check("rst_eoi", end_of_interrupt, 8'd0);
        check("rst_rotate", {5'd0, priority_rotate}, 8'd7);
        check("rst_data", data_out, 8'd0);
        check("rst_doe", {7'd0, data_out_enable}, 8'd0);
        check("rst_aip", {7'd0, ack_in_progress}, 8'd0);

        // Normal acknowledge: IR3, base 01000 -> vector 0x43
        interrupt = 8'h08;
        interrupt_vector_base = 5'b01000;
        clear_monitors();
        interrupt_acknowledge_n = 1'b0;
        tick(6);
        check("ack1_aip", {7'd0, ack_in_progress}, 8'd1);
        check("ack1_latch_pulses", 8'(latch_count), 8'd1);
        check("ack1_doe", {7'd0, data_out_enable}, 8'd0);
        interrupt_acknowledge_n = 1'b1;
        tick(6);
        check("ack1w_aip", {7'd0, ack_in_progress}, 8'd1);
        check("ack1w_doe", {7'd0, data_out_enable}, 8'd0);
        interrupt_acknowledge_n = 1'b0;
        tick(6);
        check("ack2_doe", {7'd0, data_out_enable}, 8'd1);
        check("ack2_vector", data_out, 8'h43);
        interrupt_acknowledge_n = 1'b1;
        tick(6);
        check("end_doe", {7'd0, data_out_enable}, 8'd0);
        check("end_aip", {7'd0, ack_in_progress}, 8'd0);
        check("end_data_hold", data_out, 8'h43);
        check("end_doe_cycles", 8'(doe_count), 8'd6);
        check("end_no_eoi", eoi_or, 8'd0);
        check("end_latch_total", 8'(latch_count), 8'd1);

        // OCW2: rotate on non-specific EOI, set priority, specific EOI
        highest_level_in_service = 8'h20;
        write_ocw2(8'hA0);
        check("rnseoi_eoi", end_of_interrupt, 8'h20);
        check("rnseoi_rot", {5'd0, priority_rotate}, 8'd5);
        tick(1);
        check("rnseoi_one_cycle", end_of_interrupt, 8'd0);
        write_ocw2(8'hC2);
        check("setpri_rot", {5'd0, priority_rotate}, 8'd2);
        check("setpri_eoi", end_of_interrupt, 8'd0);
        write_ocw2(8'h63);
        check("seoi_eoi", end_of_interrupt, 8'h08);
        check("seoi_rot", {5'd0, priority_rotate}, 8'd2);
        highest_level_in_service = 8'h00;
        write_ocw2(8'hA0);
        check("rnseoi_empty_eoi", end_of_interrupt, 8'd0);
        check("rnseoi_empty_rot", {5'd0, priority_rotate}, 8'd2);
        write_ocw2(8'hE6);
        check("rseoi_eoi", end_of_interrupt, 8'h40);
        check("rseoi_rot", {5'd0, priority_rotate}, 8'd6);
        tick(1);

        // Spurious acknowledge with AEOI configured
        do_reset();
        auto_eoi_config = 1'b1;
        write_ocw2(8'h80);
        tick(1);
        interrupt = 8'h00;
        clear_monitors();
        inta_pulse_low(6);
        interrupt_acknowledge_n = 1'b0;
        tick(6);
        check("spur_vector", data_out, 8'h47);
        inta_pulse_low(0);
        interrupt_acknowledge_n = 1'b1;
        tick(6);
        check("spur_no_latch", 8'(latch_count), 8'd0);
        check("spur_no_eoi", eoi_or, 8'd0);
        check("spur_rot", {5'd0, priority_rotate}, 8'd7);
        check("spur_aip", {7'd0, ack_in_progress}, 8'd0);

        // Timeout after a lone first INTA
        do_reset();
        auto_eoi_config = 1'b0;
        interrupt = 8'h08;
        interrupt_acknowledge_n = 1'b0;
        tick(4);
        interrupt_acknowledge_n = 1'b1;
        tick(4);
        check("to_waiting_aip", {7'd0, ack_in_progress}, 8'd1);
        tick(260);
        check("to_expired_aip", {7'd0, ack_in_progress}, 8'd0);
        clear_monitors();
        inta_pulse_low(6);
        check("to_late_no_doe", 8'(doe_count), 8'd0);

        // Automatic EOI: IR2 with rotate_in_aeoi set
        do_reset();
        auto_eoi_config = 1'b1;
        write_ocw2(8'h80);
        tick(1);
        interrupt = 8'h04;
        highest_level_in_service = 8'h01;
        clear_monitors();
        inta_pulse_low(6);
        interrupt_acknowledge_n = 1'b0;
        tick(6);
        interrupt_acknowledge_n = 1'b1;
        tick(6);
`ifdef PIC_AUTO_EOI_EN
        check("aeoi_eoi", eoi_or, 8'h04);
        check("aeoi_rot", {5'd0, priority_rotate}, 8'd2);
`else
        check("aeoi_eoi", eoi_or, 8'h00);
        check("aeoi_rot", {5'd0, priority_rotate}, 8'd7);
`endif

        // Automatic EOI of IR4 coinciding with an OCW2 non-specific EOI
        interrupt = 8'h10;
        inta_pulse_low(6);
        interrupt_acknowledge_n = 1'b0;
        tick(6);
        check("aeoi2_vector", data_out, 8'h44);
        interrupt_acknowledge_n = 1'b1;
        tick(2);
        write_ocw2(8'h20);
        check("aeoi2_doe_drop", {7'd0, data_out_enable}, 8'd0);
`ifdef PIC_AUTO_EOI_EN
        check("aeoi2_eoi_or", end_of_interrupt, 8'h11);
        check("aeoi2_rot", {5'd0, priority_rotate}, 8'd4);
`else
        check("aeoi2_eoi_or", end_of_interrupt, 8'h01);
        check("aeoi2_rot", {5'd0, priority_rotate}, 8'd7);
`endif
        tick(1);
        check("aeoi2_one_cycle", end_of_interrupt, 8'd0);

        // Reset while ACK2 drives the bus
        interrupt = 8'h02;
        auto_eoi_config = 1'b1;
        write_ocw2(8'hC3);
        inta_pulse_low(6);
        interrupt_acknowledge_n = 1'b0;
        tick(6);
        check("rack2_doe", {7'd0, data_out_enable}, 8'd1);
        clear_monitors();
        reset = 1'b1;
        tick(1);
        check("rack2_doe_off", {7'd0, data_out_enable}, 8'd0);
        check("rack2_aip_off", {7'd0, ack_in_progress}, 8'd0);
        check("rack2_rot", {5'd0, priority_rotate}, 8'd7);
        interrupt_acknowledge_n = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(4);
        check("rack2_no_eoi", eoi_or, 8'd0);
        check("rack2_idle", {7'd0, ack_in_progress}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
